// File: rtl/square8_seq.sv
// square8_seq: sequential shift-add squarer with valid/ready handshakes on both sides.
// Define SQUARE_RADIX4_EN to consume two multiplier bits per CALC cycle.
module square8_seq #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_root,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_square,
    output logic           busy
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
`ifdef SQUARE_RADIX4_EN
    localparam int STEPS = W / 2;
`else
    localparam int STEPS = W;
`endif
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_d;
    logic [2*W-1:0] mcand_q;
    logic [2*W-1:0] mcand_d;
    logic [W-1:0]   mplier_q;
    logic [W-1:0]   mplier_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [2*W-1:0] sq_q;
    logic           rdy_q;
    logic           vld_q;
    logic           busy_q;

    // One shift-add step of the multiplier, applied while in CALC
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q + 1'b1;
`ifdef SQUARE_RADIX4_EN
        acc_d    = acc_q
                 + (mplier_q[0] ? mcand_q : '0)
                 + (mplier_q[1] ? (mcand_q << 1) : '0);
        mcand_d  = mcand_q << 2;
        mplier_d = mplier_q >> 2;
`else
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`endif
    end

    // Control FSM and datapath registers; all outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sq_q     <= '0;
            rdy_q    <= 1'b1;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q  <= CALC;
                        mcand_q  <= {{W{1'b0}}, in_root};
                        mplier_q <= in_root;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        rdy_q    <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        sq_q    <= acc_d;
                        vld_q   <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = rdy_q;
    assign out_valid  = vld_q;
    assign out_square = sq_q;
    assign busy       = busy_q;

endmodule
